// File: rtl/tff_ctrl_pkg.sv
// tff_ctrl_pkg: command op codes and controller states for the toggle-bank sequencer
package tff_ctrl_pkg;
  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_CLEAR = 2'd1;
  localparam logic [1:0] OP_UP    = 2'd2;
  localparam logic [1:0] OP_DOWN  = 2'd3;
  typedef enum logic [1:0] {IDLE, EXEC, RUN} state_t;
endpackage

// File: rtl/tff_bank.sv
// tff_bank: WIDTH toggle cells; each bit flips when its t bit is set
module tff_bank
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge C) q <= R ? q ^ t : '0;
endmodule

// File: rtl/tff_counter_ctrl.sv
// tff_counter_ctrl: command sequencer generating the per-bit toggle vector for a toggle-flop bank
module tff_counter_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             stall,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t,
  output logic             busy,
  output logic             done,
  output logic             wrap
);
  state_t state;
  logic [1:0] op;
  logic [WIDTH-1:0] arg, rem, step;
  logic accept, stepping, last, carry;
  assign cmd_ready = state == IDLE && R;
  assign accept = cmd_valid && cmd_ready;
  assign busy = R && state != IDLE;
  assign stepping = state == RUN && !stall && rem != '0;
  assign last = state == EXEC || (state == RUN && (rem == '0 || (!stall && rem == WIDTH'(1))));
  // step[i] toggles when all lower bits are ones (up) or zeros (down); final carry marks a wrap
  always_comb begin
    carry = 1'b1;
    step = '0;
    for (int i = 0; i < WIDTH; i++) begin
      step[i] = carry;
      carry = carry & (op == OP_UP ? q[i] : ~q[i]);
    end
  end
  assign t = !R ? '0 :
             state == EXEC ? (op == OP_LOAD ? q ^ arg : q) :
             stepping ? step : '0;
  always_ff @(posedge C) begin
    if (!R) begin
      state <= IDLE;
      op <= OP_LOAD;
      arg <= '0;
      rem <= '0;
      done <= 1'b0;
      wrap <= 1'b0;
    end else begin
      done <= last;
      wrap <= stepping && carry;
      if (accept) begin
        op <= cmd_op;
        arg <= cmd_arg;
        rem <= cmd_arg;
        state <= (cmd_op == OP_LOAD || cmd_op == OP_CLEAR) ? EXEC : RUN;
      end else begin
        if (last) state <= IDLE;
        if (stepping) rem <= rem - WIDTH'(1);
      end
    end
  end
  tff_bank #(.WIDTH(WIDTH)) u_bank (.C(C), .R(R), .t(t), .q(q));
endmodule

// File: tb/tb_tff_counter_ctrl.sv
// tb_tff_counter_ctrl: directed scenarios plus random commands against an arithmetic counter model
module tb_tff_counter_ctrl;
  localparam int W = 8;
  localparam int NCMD = 10000;
  logic C = 0, R = 0, cmd_valid = 0, stall = 0;
  logic cmd_ready, busy, done, wrap;
  logic [1:0] cmd_op = 0;
  logic [W-1:0] cmd_arg = 0, q, t;
  int checks = 0, errors = 0;

  tff_counter_ctrl #(.WIDTH(W)) dut (
    .C(C), .R(R), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .stall(stall), .q(q), .t(t), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 C = ~C;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

  task automatic cyc;
    @(posedge C);
    @(negedge C);
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] arg);
    cmd_valid = 1; cmd_op = op; cmd_arg = arg;
    cyc;
    cmd_valid = 0;
    #1;
  endtask

  task automatic test_reset;
    R = 0; stall = 0; cmd_valid = 0;
    cyc; cyc;
    checks++; if (q !== 0) begin errors++; $display("FAIL rst_q got %h want 00", q); end
    checks++; if (busy !== 0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 0 || wrap !== 0) begin errors++; $display("FAIL rst_pulses got %b%b want 00", done, wrap); end
    checks++; if (cmd_ready !== 0) begin errors++; $display("FAIL rst_ready got %b want 0", cmd_ready); end
    checks++; if (t !== 0) begin errors++; $display("FAIL rst_t got %h want 00", t); end
    R = 1;
    cyc;
    checks++; if (cmd_ready !== 1) begin errors++; $display("FAIL rst_release_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_load;
    issue(2'd0, 8'hA5);
    checks++; if (busy !== 1 || cmd_ready !== 0) begin errors++; $display("FAIL load_busy got %b%b want 10", busy, cmd_ready); end
    checks++; if (t !== 8'hA5) begin errors++; $display("FAIL load_t got %h want a5", t); end
    cyc;
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL load_q got %h want a5", q); end
    checks++; if (done !== 1 || busy !== 0 || cmd_ready !== 1) begin errors++; $display("FAIL load_done got %b%b%b want 101", done, busy, cmd_ready); end
    cyc;
    checks++; if (done !== 0) begin errors++; $display("FAIL load_done_pulse got %b want 0", done); end
  endtask

  task automatic test_up_wrap;
    issue(2'd0, 8'hFE); cyc;
    issue(2'd2, 8'd3);
    checks++; if (t !== 8'h01) begin errors++; $display("FAIL up_t got %h want 01", t); end
    cyc;
    checks++; if (q !== 8'hFF || wrap !== 0 || done !== 0) begin errors++; $display("FAIL up_s1 got %h %b%b want ff 00", q, wrap, done); end
    cyc;
    checks++; if (q !== 8'h00 || wrap !== 1 || done !== 0) begin errors++; $display("FAIL up_s2 got %h %b%b want 00 10", q, wrap, done); end
    cyc;
    checks++; if (q !== 8'h01 || wrap !== 0 || done !== 1) begin errors++; $display("FAIL up_s3 got %h %b%b want 01 01", q, wrap, done); end
    cyc;
    checks++; if (done !== 0 || busy !== 0) begin errors++; $display("FAIL up_end got %b%b want 00", done, busy); end
  endtask

  task automatic test_down_stall;
    issue(2'd1, 8'h55); cyc;
    checks++; if (q !== 0) begin errors++; $display("FAIL clr_q got %h want 00", q); end
    issue(2'd3, 8'd2);
    cyc;
    checks++; if (q !== 8'hFF || wrap !== 1) begin errors++; $display("FAIL dn_s1 got %h %b want ff 1", q, wrap); end
    stall = 1; #1;
    checks++; if (t !== 0) begin errors++; $display("FAIL dn_stall_t1 got %h want 00", t); end
    cyc;
    checks++; if (q !== 8'hFF || wrap !== 0 || done !== 0) begin errors++; $display("FAIL dn_stall1 got %h %b%b want ff 00", q, wrap, done); end
    checks++; if (t !== 0) begin errors++; $display("FAIL dn_stall_t2 got %h want 00", t); end
    cyc;
    checks++; if (q !== 8'hFF || done !== 0) begin errors++; $display("FAIL dn_stall2 got %h %b want ff 0", q, done); end
    stall = 0; #1;
    checks++; if (t !== 8'h01) begin errors++; $display("FAIL dn_t got %h want 01", t); end
    cyc;
    checks++; if (q !== 8'hFE || done !== 1 || wrap !== 0) begin errors++; $display("FAIL dn_s2 got %h %b%b want fe 10", q, done, wrap); end
    cyc;
  endtask

  task automatic test_zero_n;
    issue(2'd0, 8'h3C); cyc;
    cmd_valid = 1; cmd_op = 2'd2; cmd_arg = 0;
    cyc;
    checks++; if (busy !== 1 || t !== 0) begin errors++; $display("FAIL z_run got %b %h want 1 00", busy, t); end
    cyc;
    checks++; if (done !== 1 || q !== 8'h3C || wrap !== 0 || cmd_ready !== 1) begin errors++; $display("FAIL z_done got %b %h %b%b want 1 3c 01", done, q, wrap, cmd_ready); end
    cyc;
    checks++; if (busy !== 1 || done !== 0) begin errors++; $display("FAIL z_reaccept got %b%b want 10", busy, done); end
    cmd_valid = 0;
    cyc;
    checks++; if (done !== 1 || q !== 8'h3C) begin errors++; $display("FAIL z_done2 got %b %h want 1 3c", done, q); end
    cyc;
  endtask

  task automatic test_reset_mid_run;
    issue(2'd2, 8'd100);
    repeat (40) cyc;
    checks++; if (q !== 8'h64 || busy !== 1) begin errors++; $display("FAIL mr_progress got %h %b want 64 1", q, busy); end
    R = 0; #1;
    checks++; if (cmd_ready !== 0 || t !== 0) begin errors++; $display("FAIL mr_assert got %b %h want 0 00", cmd_ready, t); end
    cyc;
    checks++; if (q !== 0 || done !== 0 || busy !== 0 || cmd_ready !== 0) begin errors++; $display("FAIL mr_reset got %h %b%b%b want 00 000", q, done, busy, cmd_ready); end
    cyc;
    checks++; if (done !== 0 || q !== 0) begin errors++; $display("FAIL mr_hold got %b %h want 0 00", done, q); end
    R = 1;
    cyc;
    checks++; if (cmd_ready !== 1 || done !== 0 || busy !== 0 || q !== 0) begin errors++; $display("FAIL mr_release got %b%b%b %h want 100 00", cmd_ready, done, busy, q); end
  endtask

  task automatic test_random;
    int qm, qn, rem, guard;
    logic [1:0] op;
    logic [W-1:0] arg;
    logic s, stepping, exp_done, exp_wrap, fin;
    qm = 0;
    for (int c = 0; c < NCMD; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        stall = 1'($urandom_range(0, 1)); #1;
        checks++; if (t !== 0) begin errors++; $display("FAIL rnd_idle_t got %h want 00", t); end
        cyc;
        checks++; if (q !== W'(qm) || done !== 0 || wrap !== 0) begin errors++; $display("FAIL rnd_idle got %h %b%b want %h 00", q, done, wrap, W'(qm)); end
      end
      op = 2'($urandom_range(0, 3));
      arg = W'($urandom);
      if (op[1]) arg = ($urandom_range(0, 15) == 0) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 5));
      stall = 1'($urandom_range(0, 1));
      cmd_valid = 1; cmd_op = op; cmd_arg = arg; #1;
      checks++; if (cmd_ready !== 1 || t !== 0) begin errors++; $display("FAIL rnd_ready got %b %h want 1 00", cmd_ready, t); end
      cyc;
      cmd_valid = 0; cmd_arg = W'($urandom);
      checks++; if (busy !== 1 || q !== W'(qm)) begin errors++; $display("FAIL rnd_accept got %b %h want 1 %h", busy, q, W'(qm)); end
      if (!op[1]) begin
        qn = (op == 2'd0) ? int'(arg) : 0;
        stall = 1'($urandom_range(0, 1)); #1;
        checks++; if (t !== W'(qm ^ qn)) begin errors++; $display("FAIL rnd_exec_t got %h want %h", t, W'(qm ^ qn)); end
        cyc;
        qm = qn;
        checks++; if (q !== W'(qm) || done !== 1 || wrap !== 0) begin errors++; $display("FAIL rnd_exec got %h %b%b want %h 10", q, done, wrap, W'(qm)); end
      end else begin
        rem = int'(arg); fin = 0; guard = 0;
        while (!fin) begin
          s = ($urandom_range(0, 3) == 0);
          stall = s; #1;
          stepping = !s && rem > 0;
          qn = !stepping ? qm : (op == 2'd2) ? (qm + 1) % 256 : (qm + 255) % 256;
          exp_wrap = stepping && ((op == 2'd2) ? (qm + 1 == 256) : (qm - 1 == -1));
          exp_done = (rem == 0) || (stepping && rem == 1);
          checks++; if (t !== W'(qm ^ qn)) begin errors++; $display("FAIL rnd_t got %h want %h", t, W'(qm ^ qn)); end
          cyc;
          if (stepping) rem--;
          qm = qn;
          checks++; if (q !== W'(qm) || done !== exp_done || wrap !== exp_wrap || busy !== !exp_done) begin
            errors++; $display("FAIL rnd_run got %h %b%b%b want %h %b%b%b", q, done, wrap, busy, W'(qm), exp_done, exp_wrap, !exp_done);
          end
          fin = exp_done;
          guard++;
          if (guard > 600) begin
            checks++; errors++; $display("FAIL rnd_guard got %0d cycles want done", guard);
            fin = 1;
          end
        end
      end
    end
    stall = 0;
  endtask

  initial begin
    test_reset;
    test_load;
    test_up_wrap;
    test_down_stall;
    test_zero_n;
    test_reset_mid_run;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
